// File: rtl/gb_alu_pkg.sv
// gb_alu_pkg: shared limb width and sequencer state encoding
package gb_alu_pkg;
  localparam int LIMB_W = 64;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/gb_alu_cla64.sv
// gb_alu_cla64: 64-bit carry-lookahead adder built from 4-bit lookahead groups
module gb_alu_cla64 (
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic        i_ci,
  output logic [63:0] o_s,
  output logic        o_c,
  output logic        o_pm,
  output logic        o_gm
);
  logic [63:0] p, g;
  logic [64:0] c;
  logic [15:0] gg, pg;
  assign p = i_a ^ i_b;
  assign g = i_a & i_b;
  always_comb begin
    c = '0;
    gg = '0;
    pg = '0;
    c[0] = i_ci;
    for (int k = 0; k < 16; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & c[4*k+1]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & c[4*k+2]);
      c[4*k+4] = gg[k] | (pg[k] & c[4*k]);
    end
  end
  assign o_s  = p ^ c[63:0];
  assign o_c  = c[64];
  assign o_pm = &p;
  // p and g are exclusive per bit, so full propagate implies no generate
  assign o_gm = o_c & ~o_pm;
endmodule

// File: rtl/gb_alu_mpadd_seq.sv
// gb_alu_mpadd_seq: limb-serial multi-precision add/subtract around one cla64
module gb_alu_mpadd_seq
  import gb_alu_pkg::*;
#(
  parameter int LIMBS = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [LIMB_W*LIMBS-1:0] i_a,
  input  logic [LIMB_W*LIMBS-1:0] i_b,
  input  logic                    i_sub,
  input  logic                    i_ci,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [LIMB_W*LIMBS-1:0] o_s,
  output logic                    o_c,
  output logic                    o_z,
  output logic                    o_v
);
  localparam int W  = LIMB_W * LIMBS;
  localparam int CW = LIMBS > 1 ? $clog2(LIMBS) : 1;
  state_t state, state_nxt;
  logic [W-1:0] a_sr, b_sr;
  logic [W+LIMB_W-1:0] s_cat;
  logic [LIMB_W-1:0] sum;
  logic [CW-1:0] cnt;
  logic c_reg, zacc, co, last, unused_pm, unused_gm;
  gb_alu_cla64 u_cla (
    .i_a (a_sr[LIMB_W-1:0]),
    .i_b (b_sr[LIMB_W-1:0]),
    .i_ci(c_reg),
    .o_s (sum),
    .o_c (co),
    .o_pm(unused_pm),
    .o_gm(unused_gm)
  );
  assign last  = cnt == CW'(LIMBS - 1);
  assign s_cat = {sum, o_s};
  always_comb begin
    o_ready   = state == IDLE;
    o_valid   = state == DONE;
    state_nxt = state == IDLE ? (i_valid ? RUN : IDLE)
              : state == RUN  ? (last ? DONE : RUN)
              : (i_ready ? IDLE : DONE);
  end
  always_ff @(posedge i_clk)
    if (i_rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      o_s   <= '0;
      c_reg <= 1'b0;
      zacc  <= 1'b0;
      cnt   <= '0;
      o_c   <= 1'b0;
      o_z   <= 1'b0;
      o_v   <= 1'b0;
    end else if (state == IDLE && i_valid) begin
      // subtraction is A + ~B + ~borrow
      a_sr  <= i_a;
      b_sr  <= i_b ^ {W{i_sub}};
      c_reg <= i_sub ^ i_ci;
      zacc  <= 1'b0;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> LIMB_W;
      b_sr  <= b_sr >> LIMB_W;
      o_s   <= s_cat[W+LIMB_W-1:LIMB_W];
      c_reg <= co;
      zacc  <= zacc | (|sum);
      if (last) begin
        o_c <= co;
        o_v <= (a_sr[LIMB_W-1] == b_sr[LIMB_W-1]) && (sum[LIMB_W-1] != a_sr[LIMB_W-1]);
        o_z <= ~(zacc | (|sum));
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gb_alu_mpadd_seq.sv
// tb_gb_alu_mpadd_seq: directed and random ops checked against a W-bit arithmetic model
module tb_gb_alu_mpadd_seq;
  localparam int LIMBS = 4;
  localparam int W = 64 * LIMBS;
  logic i_clk = 0, i_rst = 1, i_valid = 0, i_sub = 0, i_ci = 0, i_ready = 0;
  logic [W-1:0] i_a = '0, i_b = '0, o_s;
  logic o_ready, o_valid, o_c, o_z, o_v;
  int tests = 0, fails = 0;
  gb_alu_mpadd_seq #(.LIMBS(LIMBS)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .i_ci(i_ci),
    .o_valid(o_valid), .i_ready(i_ready), .o_s(o_s),
    .o_c(o_c), .o_z(o_z), .o_v(o_v)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < W / 32; i++) r = {r[W-33:0], $urandom()};
    return r;
  endfunction
  // {v, z, c, s} computed from the arithmetic meaning of the op
  function automatic logic [W+2:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub, input logic ci);
    logic [W:0] f;
    logic [W-1:0] s;
    logic c, v;
    if (sub) begin
      s = a - b - W'(ci);
      c = {1'b0, a} >= ({1'b0, b} + (W+1)'(ci));
      v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    end else begin
      f = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
      s = f[W-1:0];
      c = f[W];
      v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end
    return {v, s == '0, c, s};
  endfunction
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic ci, input int hold, input string tag);
    logic [W+2:0] e;
    logic [W-1:0] held;
    int n;
    e = ref_op(a, b, sub, ci);
    @(negedge i_clk);
    check({tag, "_rdy"}, (W+1)'(o_ready), (W+1)'(1));
    i_valid = 1; i_a = a; i_b = b; i_sub = sub; i_ci = ci;
    @(posedge i_clk);
    n = 1;
    @(negedge i_clk);
    i_valid = $urandom_range(0, 1); i_a = rnd(); i_b = rnd(); i_sub = ~sub; i_ci = ~ci;
    while (o_valid !== 1'b1 && n < 20) begin
      @(posedge i_clk);
      n++;
      @(negedge i_clk);
    end
    i_valid = 0;
    check({tag, "_lat"}, (W+1)'(n), (W+1)'(LIMBS + 1));
    check({tag, "_s"}, {1'b0, o_s}, {1'b0, e[W-1:0]});
    check({tag, "_czv"}, (W+1)'({o_c, o_z, o_v}), (W+1)'({e[W], e[W+1], e[W+2]}));
    held = o_s;
    for (int i = 0; i < hold; i++) begin
      @(negedge i_clk);
      check({tag, "_hold"}, {o_s, o_valid}, {held, 1'b1});
      check({tag, "_hold_rdy"}, (W+1)'(o_ready), '0);
    end
    i_ready = 1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_ready = 0;
    check({tag, "_idle"}, (W+1)'({o_ready, o_valid}), (W+1)'(2'b10));
  endtask
  initial begin
    logic [W-1:0] ones, a, b;
    ones = '1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 0;
    check("rst_hs", (W+1)'({o_ready, o_valid}), (W+1)'(2'b10));
    check("rst_s", {1'b0, o_s}, '0);
    check("rst_flags", (W+1)'({o_c, o_z, o_v}), '0);
    run_op(ones, 1, 0, 0, 0, "t1");
    check("t1_exact", (W+1)'({o_s == '0, o_c, o_z, o_v}), (W+1)'(4'b1110));
    run_op('0, 1, 1, 0, 0, "t2");
    check("t2_exact", {o_s, o_c}, {ones, 1'b0});
    run_op(ones >> 1, 1, 0, 0, 0, "t3");
    check("t3_exact", {o_s, o_v}, {1'b1, {(W-1){1'b0}}, 1'b1});
    a = '0; a[63:0] = '1;
    run_op(a, 1, 0, 0, 0, "t4");
    check("t4_limbs", (W+1)'(o_s[127:0]), (W+1)'({64'd1, 64'd0}));
    run_op(rnd(), rnd(), 0, 1, 10, "t5");
    run_op(rnd(), rnd(), 1, 1, 0, "t5_b2b");
    @(negedge i_clk);
    i_valid = 1; i_a = rnd(); i_b = rnd(); i_sub = 0; i_ci = 0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 0;
    check("t6_hs", (W+1)'({o_ready, o_valid}), (W+1)'(2'b10));
    check("t6_s", {1'b0, o_s}, '0);
    check("t6_flags", (W+1)'({o_c, o_z, o_v}), '0);
    run_op(rnd(), rnd(), 1, 0, 0, "t6_new");
    run_op(ones, ones, 1, 0, 0, "sub_zero");
    run_op(ones, '0, 1, 1, 0, "sub_borrow");
    run_op('0, '0, 0, 0, 0, "add_zero");
    for (int i = 0; i < 20; i++) begin
      a = rnd(); b = rnd();
      if (i % 4 == 0) b = a;
      if (i % 5 == 1) a[W-1] = ~b[W-1] ^ a[W-1] ^ a[W-1];
      run_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), i % 3, "rnd");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
